// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: software-fed byte queue that drains into the system UART.
// Bytes pushed through the TXDATA window are written one at a time to the
// UART TXDATA register (offset 0x0c). Each write waits for the UART tx-done
// pulse, or for a bounded timeout, before the next byte is offered.
//
// Handshake: u_we_o is a single-cycle write pulse carrying the head byte on
// u_data_o. No further pulse is issued until tx_done_i has been seen while in
// WAIT, or until the WAIT timeout expires. tx_done_i is a pulse; outside WAIT
// it is ignored. The FSM state is visible to software as STATUS.busy.
module uart_tx_fifo #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  sel_i,
  input  logic        we_i,
  input  logic [7:0]  raddr_i,
  input  logic        rd_i,
  output logic [31:0] data_o,
  output logic [7:0]  u_waddr_o,
  output logic [31:0] u_data_o,
  output logic [3:0]  u_sel_o,
  output logic        u_we_o,
  input  logic        tx_done_i,
  output logic        irq_empty
);

  localparam logic [7:0]  ADDR_CTRL   = 8'h00;
  localparam logic [7:0]  ADDR_STATUS = 8'h04;
  localparam logic [7:0]  ADDR_TXDATA = 8'h08;
  localparam logic [7:0]  UART_TXDATA = 8'h0c;
  localparam logic [AW:0] DEPTH_CNT   = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE     = (AW+1)'(1);
  localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // storage and pointers
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  // software-visible control/status
  logic ctrl_en;
  logic ctrl_irq;
  logic ovf;

  // drain FSM
  state_t      state;
  logic [15:0] tmo;

  // decoded strobes
  logic        reg_wr;
  logic        push_req;
  logic        flush;
  logic        ovf_clr;
  logic        full;
  logic        empty;
  logic        push_ok;
  logic        ovf_set;
  logic        pop;
  logic        start;
  logic        wait_exit;
  logic [31:0] status;
  logic [31:0] rdata;

  // Only byte lane 0 carries register content; the other bits are ignored.
  logic unused_bits;
  assign unused_bits = ^{data_i[31:8], sel_i[3:1]};

  // The UART target register and byte lane never change.
  assign u_waddr_o = UART_TXDATA;
  assign u_sel_o   = 4'b0001;

  // Bus write decode: all register writes need byte lane 0 enabled.
  always_comb begin
    reg_wr   = we_i & sel_i[0];
    push_req = reg_wr & (waddr_i == ADDR_TXDATA);
    flush    = reg_wr & (waddr_i == ADDR_CTRL) & data_i[1];
    ovf_clr  = reg_wr & (waddr_i == ADDR_STATUS) & data_i[2];
  end

  // Queue bookkeeping. Fullness is judged on the current count, so a push
  // landing on the same edge as a pop from a full queue is still dropped.
  // A flush drops any same-cycle push and does not count it as overflow.
  always_comb begin
    full      = (count == DEPTH_CNT);
    empty     = (count == '0);
    push_ok   = push_req & ~full & ~flush;
    ovf_set   = push_req & full & ~flush;
    pop       = (state == ST_ISSUE) & ~empty;
    start     = (state == ST_IDLE) & ctrl_en & ~empty & ~flush;
    wait_exit = (state == ST_WAIT) & (tx_done_i | (tmo == TMO_LAST));
  end

  // Byte storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= data_i[7:0];
    end
  end

  // Pointers and occupancy; flush empties the queue but leaves the FSM alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // CTRL register and sticky overflow flag (a new overflow wins over clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_en  <= 1'b0;
      ctrl_irq <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (reg_wr && (waddr_i == ADDR_CTRL)) begin
        ctrl_en  <= data_i[0];
        ctrl_irq <= data_i[2];
      end
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  // Drain FSM with registered UART strobe, data and empty interrupt.
  // IDLE -> ISSUE asserts u_we_o for exactly the ISSUE cycle; the head byte is
  // popped on the ISSUE -> WAIT edge. A reset abandons any byte in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      tmo       <= '0;
      u_we_o    <= 1'b0;
      u_data_o  <= '0;
      irq_empty <= 1'b0;
    end else begin
      u_we_o    <= 1'b0;
      irq_empty <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_ISSUE;
            u_we_o   <= 1'b1;
            u_data_o <= {24'h0, mem[rd_ptr]};
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
          tmo   <= '0;
        end
        ST_WAIT: begin
          if (wait_exit) begin
            state     <= ST_IDLE;
            irq_empty <= empty & ctrl_irq;
          end else begin
            tmo <= tmo + 16'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // STATUS image: empty, full, ovf, busy, and the occupancy count at [AW+8:8].
  always_comb begin
    status         = '0;
    status[0]      = empty;
    status[1]      = full;
    status[2]      = ovf;
    status[3]      = (state != ST_IDLE);
    status[AW+8:8] = count;
  end

  // Read mux; flush is self-clearing so it always reads back 0.
  always_comb begin
    rdata = '0;
    case (raddr_i)
      ADDR_CTRL:   rdata = {29'd0, ctrl_irq, 1'b0, ctrl_en};
      ADDR_STATUS: rdata = status;
      default:     rdata = '0;
    endcase
  end

  // Registered read data, updated only on a read strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_o <= '0;
    end else if (rd_i) begin
      data_o <= rdata;
    end
  end

  // Occupancy can never exceed the queue depth.
  assert property (@(posedge clk) disable iff (rst) count <= DEPTH_CNT);

  // The UART write strobe is always a single-cycle pulse.
  assert property (@(posedge clk) disable iff (rst) u_we_o |=> !u_we_o);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo.
// Bytes are pushed to exp_q as they are written; every UART write pulse pops
// the oldest entry and compares it with u_data_o. Inputs are driven on the
// falling edge and outputs are sampled on the falling edge.
module tb_uart_tx_fifo;

  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int TIMEOUT = 20;

  // clock/reset and DUT signals
  logic        clk;
  logic        rst;
  logic [7:0]  waddr_i;
  logic [31:0] data_i;
  logic [3:0]  sel_i;
  logic        we_i;
  logic [7:0]  raddr_i;
  logic        rd_i;
  logic [31:0] data_o;
  logic [7:0]  u_waddr_o;
  logic [31:0] u_data_o;
  logic [3:0]  u_sel_o;
  logic        u_we_o;
  logic        tx_done_i;
  logic        irq_empty;

  uart_tx_fifo #(
    .DEPTH   (DEPTH),
    .AW      (AW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .waddr_i   (waddr_i),
    .data_i    (data_i),
    .sel_i     (sel_i),
    .we_i      (we_i),
    .raddr_i   (raddr_i),
    .rd_i      (rd_i),
    .data_o    (data_o),
    .u_waddr_o (u_waddr_o),
    .u_data_o  (u_data_o),
    .u_sel_o   (u_sel_o),
    .u_we_o    (u_we_o),
    .tx_done_i (tx_done_i),
    .irq_empty (irq_empty)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------------------------------------------------------- scoreboard
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  int n_issue        = 0;
  int last_issue_cyc = 0;
  int prev_issue_cyc = 0;
  int irq_cnt        = 0;
  int push_cyc       = 0;
  int ack_delay      = 0;

  always @(negedge clk) begin
    if (irq_empty) irq_cnt++;
    if (u_we_o) begin
      if (n_issue > 0)
        check_eq("issue_spacing", (cyc - last_issue_cyc >= 3) ? 32'd1 : 32'd0, 32'd1);
      check_eq("u_waddr", {24'h0, u_waddr_o}, 32'h0000_000c);
      check_eq("u_sel", {28'h0, u_sel_o}, 32'h0000_0001);
      check_eq("issue_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() > 0) begin
        exp_b = exp_q.pop_front();
        check_eq("u_data", u_data_o, {24'h0, exp_b});
      end
      prev_issue_cyc = last_issue_cyc;
      last_issue_cyc = cyc;
      n_issue++;
    end
  end

  // UART model: pulse tx_done_i ack_delay cycles after each write (0 = never).
  initial begin
    tx_done_i = 1'b0;
    forever begin
      @(negedge clk);
      if (u_we_o && ack_delay > 0) begin
        repeat (ack_delay) @(negedge clk);
        tx_done_i = 1'b1;
        @(negedge clk);
        tx_done_i = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic wr_reg(input logic [7:0] addr, input logic [31:0] data);
    waddr_i = addr;
    data_i  = data;
    sel_i   = 4'b0001;
    we_i    = 1'b1;
    @(negedge clk);
    we_i    = 1'b0;
    sel_i   = 4'b0000;
  endtask

  task automatic push(input logic [7:0] b, input bit accept);
    if (accept) exp_q.push_back(b);
    wr_reg(8'h08, {24'hABCDEF, b});
    push_cyc = cyc;
  endtask

  task automatic rd_reg(input logic [7:0] addr, output logic [31:0] data);
    raddr_i = addr;
    rd_i    = 1'b1;
    @(negedge clk);
    rd_i    = 1'b0;
    data    = data_o;
  endtask

  task automatic check_reg(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    logic [31:0] v;
    rd_reg(addr, v);
    check_eq(tag, v, exp);
  endtask

  task automatic wait_issues(input int target, input int budget);
    int k = 0;
    while (n_issue < target && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check_eq("issue_wait", (n_issue >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check_eq("drain", exp_q.size(), 32'd0);
    repeat (30) @(negedge clk);
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got %0d checks, expected completion", n_checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    int base;
    rst     = 1'b1;
    waddr_i = '0;
    data_i  = '0;
    sel_i   = '0;
    we_i    = 1'b0;
    raddr_i = '0;
    rd_i    = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    check_eq("rst_u_we", {31'h0, u_we_o}, 32'd0);
    check_eq("rst_u_waddr", {24'h0, u_waddr_o}, 32'h0c);
    check_eq("rst_u_sel", {28'h0, u_sel_o}, 32'h1);
    check_eq("rst_u_data", u_data_o, 32'h0);
    check_eq("rst_irq", {31'h0, irq_empty}, 32'd0);
    check_eq("rst_data_o", data_o, 32'h0);
    check_reg("rst_status", 8'h04, 32'h0000_0001);
    check_reg("rst_ctrl", 8'h00, 32'h0000_0000);

    // 1: single byte, ack 10 cycles after the write, empty irq enabled
    ack_delay = 10;
    wr_reg(8'h00, 32'h0000_0005);
    check_reg("t1_ctrl", 8'h00, 32'h0000_0005);
    check_reg("t1_txdata_rd", 8'h08, 32'h0);
    check_reg("t1_unmapped_rd", 8'h10, 32'h0);
    base = n_issue;
    push(8'h55, 1'b1);
    wait_issues(base + 1, 10);
    // push sampled at edge N, u_we_o registered at edge N+1 (high in cycle N+2)
    check_eq("t1_latency", last_issue_cyc - push_cyc, 32'd1);
    @(negedge clk);
    check_reg("t1_status_busy", 8'h04, 32'h0000_0009);
    wait_drain(50);
    check_eq("t1_irq", irq_cnt, 32'd1);
    check_reg("t1_status_idle", 8'h04, 32'h0000_0001);

    // 2: fill with en=0, overflow, clear ovf, then drain in order
    wr_reg(8'h00, 32'h0000_0000);
    for (int i = 1; i <= 16; i++) push(8'(i), 1'b1);
    check_reg("t2_full", 8'h04, 32'h0000_1002);
    push(8'hAA, 1'b0);
    check_reg("t2_ovf", 8'h04, 32'h0000_1006);
    wr_reg(8'h04, 32'h0000_0004);
    check_reg("t2_ovf_clr", 8'h04, 32'h0000_1002);
    ack_delay = 1;
    wr_reg(8'h00, 32'h0000_0001);
    wait_drain(200);
    check_reg("t2_empty", 8'h04, 32'h0000_0001);

    // 5: full queue, push on the same edge that ISSUE pops
    ack_delay = 0;
    wr_reg(8'h00, 32'h0000_0000);
    for (int i = 0; i < 16; i++) push(8'hB0 + 8'(i), 1'b1);
    base = n_issue;
    wr_reg(8'h00, 32'h0000_0001);
    wait_issues(base + 1, 10);
    push(8'hAA, 1'b0);
    check_reg("t5_status", 8'h04, 32'h0000_0F0C);
    wr_reg(8'h04, 32'h0000_0004);
    ack_delay = 1;
    wait_drain(300);
    check_reg("t5_empty", 8'h04, 32'h0000_0001);

    // 3: flush during WAIT of the first of three bytes
    ack_delay = 8;
    base = n_issue;
    push(8'h71, 1'b1);
    push(8'h72, 1'b1);
    push(8'h73, 1'b1);
    wait_issues(base + 1, 10);
    exp_q.delete();
    wr_reg(8'h00, 32'h0000_0003);
    repeat (30) @(negedge clk);
    check_eq("t3_one_issue", n_issue - base, 32'd1);
    check_reg("t3_status", 8'h04, 32'h0000_0001);
    check_reg("t3_ctrl", 8'h00, 32'h0000_0001);

    // 4: no ack, WAIT times out after TIMEOUT cycles
    ack_delay = 0;
    base = n_issue;
    push(8'h3C, 1'b1);
    push(8'h3D, 1'b1);
    wait_issues(base + 2, 80);
    // ISSUE, 20 WAIT cycles, IDLE, then the next ISSUE
    check_eq("t4_timeout_gap", last_issue_cyc - prev_issue_cyc, 32'd22);
    repeat (30) @(negedge clk);
    check_reg("t4_status", 8'h04, 32'h0000_0001);

    // 6: reset while a byte is in WAIT
    base = n_issue;
    push(8'h11, 1'b1);
    push(8'h22, 1'b1);
    wait_issues(base + 1, 10);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    check_eq("t6_u_we", {31'h0, u_we_o}, 32'd0);
    check_eq("t6_data_o", data_o, 32'h0);
    rst = 1'b0;
    check_reg("t6_status", 8'h04, 32'h0000_0001);
    check_reg("t6_ctrl", 8'h00, 32'h0000_0000);
    repeat (10) @(negedge clk);
    check_eq("t6_no_issue", n_issue - base, 32'd1);

    // empty irq only fired in scenario 1
    check_eq("irq_total", irq_cnt, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
